autosym_probe: RTL and testbench
================================

AUTOSYM_PROBE -- requirements
Module: autosym_probe

Interface
REQ-001 Parameter SETTLE, default 0, extra hold cycles per applied vector before y0 is sampled (range 0..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  one-cycle request to begin a probe run; honoured only in IDLE.
REQ-005 x0..x4  output  1 each  input vector driven to the 5-input combinational function under test; x0 is the LSB of the vector index.
REQ-006 y0  input  1  function-under-test output, sampled by this block.
REQ-007 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-008 done  output  1  one-cycle pulse marking valid results.
REQ-009 truth_table  output  32  bit i = sampled y0 for vector i.
REQ-010 lf_mask  output  32  bit a = 1 iff f(x) = f(x^a) for all x (linear space L_f).
REQ-011 k  output  3  autosymmetry degree, log2 of popcount(lf_mask), range 0..5.

Function
REQ-012 The FSM SHALL have states IDLE, DRIVE, SCAN, DONE.
REQ-013 IDLE: x0..x4 = 0, busy = 0; start = 1 moves to DRIVE with vector index v = 0 and hold counter = 0.
REQ-014 DRIVE: {x4..x0} = v, held SETTLE+1 cycles; y0 is written to truth_table[v] on the last hold cycle.
REQ-015 After sampling v = 31, DRIVE SHALL go to SCAN with a = 1; otherwise v increments and the hold counter clears.
REQ-016 SCAN: one candidate per cycle, a = 1..31; lf_mask[a] = 1 iff truth_table[x] == truth_table[x^a] for all 32 x, evaluated in one cycle.
REQ-017 lf_mask[0] SHALL be forced to 1 at SCAN entry.
REQ-018 After a = 31, SCAN SHALL go to DONE; DONE computes k from popcount(lf_mask), pulses done for one cycle, clears busy, returns to IDLE.
REQ-019 Popcount of lf_mask is always a power of two; k SHALL be the exact log2; no rounding path is required.
REQ-020 Latency: done SHALL be high exactly 32*(SETTLE+1)+32 cycles after the cycle where start is accepted.
REQ-021 start while busy or in DONE SHALL be ignored and SHALL NOT queue.
REQ-022 truth_table, lf_mask and k SHALL hold their values from done until the next accepted start.
REQ-023 At an accepted start, truth_table, lf_mask and k SHALL be cleared to 0.
REQ-024 y0 SHALL be ignored outside the sampling cycle.

Reset
REQ-025 rst_n = 0 SHALL force IDLE, v = 0, a = 0, hold counter = 0, x0..x4 = 0, busy = 0, done = 0, truth_table = 0, lf_mask = 0, k = 0 at the next edge.
REQ-026 Reset mid-run SHALL abort the run with no done pulse; partial results SHALL be discarded.

Structure
REQ-027 A shared package SHALL hold the state enum, N_IN = 5, N_VEC = 32, and the SETTLE width constant.
REQ-028 A single combinational sub-module, autosym_xor_check, SHALL take truth_table and a and return the 1-bit invariance result.

Verification
REQ-029 y0 tied 0, SETTLE = 0 -> truth_table = 0x00000000, lf_mask = 0xFFFFFFFF, k = 5, done 64 cycles after start.
REQ-030 y0 = x0 -> truth_table = 0xAAAAAAAA, lf_mask = 0x55555555, k = 4.
REQ-031 y0 = x0^x1, SETTLE = 3 -> truth_table = 0x66666666, lf_mask = 0x99999999, k = 4, done 160 cycles after start.
REQ-032 y0 = AND of x0..x4 -> truth_table = 0x80000000, lf_mask = 0x00000001, k = 0.
REQ-033 start pulsed again at cycle 10 of a run -> ignored; exactly one done, at the nominal cycle.
REQ-034 rst_n low at cycle 20 of a run -> next cycle IDLE with all outputs 0; no done pulse; a fresh start then completes normally.

Source files
------------

// File: rtl/autosym_probe_pkg.sv
// Shared types and constants for the autosymmetry probe: FSM states, vector sizes
// and the log2 helper used to derive the autosymmetry degree.
package autosym_probe_pkg;

    localparam int unsigned N_IN     = 5;
    localparam int unsigned N_VEC    = 32;
    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StScan,
        StDone
    } state_e;

    // The linear space of f always has a power-of-two size, so the highest set bit
    // of the popcount is the exact log2.
    function automatic logic [2:0] log2_pow2(input logic [N_VEC-1:0] mask);
        logic [5:0] cnt;
        logic [2:0] res;
        cnt = '0;
        res = '0;
        for (int i = 0; i < int'(N_VEC); i++) begin
            cnt = cnt + {5'd0, mask[i]};
        end
        for (int b = 0; b < 6; b++) begin
            if (cnt[b]) begin
                res = 3'(b);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/autosym_xor_check.sv
// Single-cycle invariance test: reports whether the stored truth table is unchanged
// when every input vector is XOR-translated by the candidate a.
module autosym_xor_check
    import autosym_probe_pkg::*;
(
    input  logic [N_VEC-1:0] truth_table,
    input  logic [N_IN-1:0]  a,
    output logic             invariant
);

    always_comb begin
        invariant = 1'b1;
        for (int x = 0; x < int'(N_VEC); x++) begin
            if (truth_table[N_IN'(x)] != truth_table[N_IN'(x) ^ a]) begin
                invariant = 1'b0;
            end
        end
    end

endmodule

// File: rtl/autosym_probe.sv
// Drives all 32 input vectors into an external 5-input function, records its truth
// table, then scans every XOR translation to find the linear space and its degree.
module autosym_probe
    import autosym_probe_pkg::*;
#(
    parameter int unsigned SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             x0,
    output logic             x1,
    output logic             x2,
    output logic             x3,
    output logic             x4,
    input  logic             y0,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] truth_table,
    output logic [N_VEC-1:0] lf_mask,
    output logic [2:0]       k
);

    localparam logic [SETTLE_W-1:0] HoldLast = SETTLE_W'(SETTLE);
    localparam logic [N_IN-1:0]     VecLast  = N_IN'(N_VEC - 1);

    state_e              state_q;
    logic [N_IN-1:0]     vec_q;
    logic [N_IN-1:0]     cand_q;
    logic [SETTLE_W-1:0] hold_q;
    logic [N_IN-1:0]     xvec_q;
    logic                busy_q;
    logic                done_q;
    logic [N_VEC-1:0]    tt_q;
    logic [N_VEC-1:0]    lf_q;
    logic [2:0]          k_q;
    logic                invariant;

    autosym_xor_check u_xor_check (
        .truth_table (tt_q),
        .a           (cand_q),
        .invariant   (invariant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= '0;
            cand_q  <= '0;
            hold_q  <= '0;
            xvec_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= '0;
            lf_q    <= '0;
            k_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StDrive;
                        vec_q   <= '0;
                        hold_q  <= '0;
                        xvec_q  <= '0;
                        busy_q  <= 1'b1;
                        tt_q    <= '0;
                        lf_q    <= '0;
                        k_q     <= '0;
                    end
                end
                StDrive: begin
                    if (hold_q == HoldLast) begin
                        // y0 is only looked at on the final hold cycle of each vector.
                        tt_q[vec_q] <= y0;
                        hold_q      <= '0;
                        if (vec_q == VecLast) begin
                            state_q  <= StScan;
                            cand_q   <= N_IN'(1);
                            xvec_q   <= '0;
                            lf_q[0]  <= 1'b1;
                        end else begin
                            vec_q  <= vec_q + N_IN'(1);
                            xvec_q <= vec_q + N_IN'(1);
                        end
                    end else begin
                        hold_q <= hold_q + SETTLE_W'(1);
                    end
                end
                StScan: begin
                    lf_q[cand_q] <= invariant;
                    if (cand_q == VecLast) begin
                        state_q <= StDone;
                    end else begin
                        cand_q <= cand_q + N_IN'(1);
                    end
                end
                StDone: begin
                    k_q     <= log2_pow2(lf_q);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    vec_q   <= '0;
                    cand_q  <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign {x4, x3, x2, x1, x0} = xvec_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tt_q;
    assign lf_mask     = lf_q;
    assign k           = k_q;

    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);
    a_done_idle:  assert property (@(posedge clk) disable iff (!rst_n) done_q |-> !busy_q);

endmodule

// File: tb/tb_autosym_probe.sv
// Directed bench for autosym_probe: two instances (SETTLE 0 and 3) probing small
// known functions, with hand-computed tables, masks, degrees and latencies.
module tb_autosym_probe;

    logic        clk;
    logic        rst_n;
    logic        st;
    logic        use3;
    int          fsel;

    logic        start0, start3;
    logic        y0_0, y0_3;
    logic [4:0]  xv0, xv3;
    logic        busy0, busy3, done0, done3;
    logic [31:0] tt0, tt3, lf0, lf3;
    logic [2:0]  k0, k3;

    logic        busy_s, done_s;
    logic [4:0]  x_s;
    logic [31:0] tt_s, lf_s;
    logic [2:0]  k_s;

    int n_checks;
    int n_errors;

    autosym_probe #(.SETTLE(0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start0),
        .x0          (xv0[0]),
        .x1          (xv0[1]),
        .x2          (xv0[2]),
        .x3          (xv0[3]),
        .x4          (xv0[4]),
        .y0          (y0_0),
        .busy        (busy0),
        .done        (done0),
        .truth_table (tt0),
        .lf_mask     (lf0),
        .k           (k0)
    );

    autosym_probe #(.SETTLE(3)) dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start3),
        .x0          (xv3[0]),
        .x1          (xv3[1]),
        .x2          (xv3[2]),
        .x3          (xv3[3]),
        .x4          (xv3[4]),
        .y0          (y0_3),
        .busy        (busy3),
        .done        (done3),
        .truth_table (tt3),
        .lf_mask     (lf3),
        .k           (k3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic fut(input int f, input logic [4:0] x);
        case (f)
            1:       return x[0];
            2:       return x[0] ^ x[1];
            3:       return &x;
            default: return 1'b0;
        endcase
    endfunction

    assign start0 = use3 ? 1'b0 : st;
    assign start3 = use3 ? st : 1'b0;

    always_comb begin
        y0_0   = fut(fsel, xv0);
        y0_3   = fut(fsel, xv3);
        busy_s = use3 ? busy3 : busy0;
        done_s = use3 ? done3 : done0;
        x_s    = use3 ? xv3 : xv0;
        tt_s   = use3 ? tt3 : tt0;
        lf_s   = use3 ? lf3 : lf0;
        k_s    = use3 ? k3 : k0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " x"}, {27'd0, x_s}, 32'd0);
        check({tag, " busy/done"}, {30'd0, busy_s, done_s}, 32'd0);
        check({tag, " tt"}, tt_s, 32'd0);
        check({tag, " lf"}, lf_s, 32'd0);
        check({tag, " k"}, {29'd0, k_s}, 32'd0);
    endtask

    // Starts one run and follows it cycle by cycle; rst_at > 0 aborts it with reset.
    task automatic run_case(input string name, input bit on3, input int fn,
                            input logic [31:0] exp_tt, input logic [31:0] exp_lf,
                            input logic [2:0] exp_k, input bit glitch, input int rst_at);
        int lat;
        int ndone;
        int nominal;
        int settle;
        use3    = on3;
        fsel    = fn;
        settle  = on3 ? 3 : 0;
        nominal = 32 * (settle + 1) + 32;
        st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        check({name, " busy@start"}, {31'd0, busy_s}, 32'd1);
        check({name, " cleared"}, tt_s | lf_s | {29'd0, k_s}, 32'd0);
        lat   = -1;
        ndone = 0;
        for (int n = 1; n <= nominal + 20; n++) begin
            if (glitch && n == 10) st = 1'b1;
            if (glitch && n == 11) st = 1'b0;
            if (rst_at > 0 && n == rst_at) rst_n = 1'b0;
            @(posedge clk); #1;
            if (rst_at > 0 && n == rst_at) begin
                check_zero({name, " rst"});
                rst_n = 1'b1;
            end
            if (n == 5 && rst_at == 0) begin
                check({name, " x@5"}, {27'd0, x_s}, 32'(5 / (settle + 1)));
            end
            if (done_s) begin
                ndone++;
                if (lat < 0) begin
                    lat = n;
                    check({name, " busy@done"}, {31'd0, busy_s}, 32'd0);
                end
            end
        end
        if (rst_at > 0) begin
            check({name, " no done"}, 32'(ndone), 32'd0);
        end else begin
            check({name, " latency"}, 32'(lat), 32'(nominal));
            check({name, " ndone"}, 32'(ndone), 32'd1);
            check({name, " tt"}, tt_s, exp_tt);
            check({name, " lf"}, lf_s, exp_lf);
            check({name, " k"}, {29'd0, k_s}, {29'd0, exp_k});
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        st       = 1'b0;
        use3     = 1'b0;
        fsel     = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset0");
        use3 = 1'b1;
        check_zero("reset3");
        use3 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_case("zero",  1'b0, 0, 32'h0000_0000, 32'hFFFF_FFFF, 3'd5, 1'b0, 0);
        run_case("x0",    1'b0, 1, 32'hAAAA_AAAA, 32'h5555_5555, 3'd4, 1'b0, 0);
        run_case("x0^x1", 1'b1, 2, 32'h6666_6666, 32'h9999_9999, 3'd4, 1'b0, 0);
        run_case("and",   1'b0, 3, 32'h8000_0000, 32'h0000_0001, 3'd0, 1'b0, 0);
        run_case("glitch", 1'b0, 1, 32'hAAAA_AAAA, 32'h5555_5555, 3'd4, 1'b1, 0);
        run_case("abort", 1'b0, 2, 32'h0, 32'h0, 3'd0, 1'b0, 20);
        run_case("fresh", 1'b0, 2, 32'h6666_6666, 32'h9999_9999, 3'd4, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
